uart_rx_mmio: RTL and testbench

Memory-mapped UART receiver, the receive-side counterpart of the UART transmit interface at 0x10000000. It deserialises 8N1 frames from the i_rx pin into a small FIFO. It exposes a data register and a status register to the LSU load path. The LSU ORs o_rdata into its load mux whenever o_hit is high; no CPU stall is generated.

---
 rtl/uart_rx_mmio.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
// Exposes a data register (read pops one byte) and a status register
// (read clears the sticky overrun / frame-error flags) to the LSU load path.
module uart_rx_mmio #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] DATA_ADDR  = 32'h10000004,
  parameter logic [31:0] STAT_ADDR  = 32'h10000008
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  input  logic        i_ren,
  input  logic [31:0] i_address,
  output logic [31:0] o_rdata,
  output logic        o_hit,
  output logic        o_rx_avail
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_FW       = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               rx_meta_q, rx_s_q;
  logic               shift_en, stop_ok, stop_bad;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0]  count_q, count_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;

  logic               full, empty, pop, push, ovr_set, stat_rd;
  logic               data_sel, stat_sel;
  logic [2:0]         count3;
  logic [31:0]        status;

  // Two-flop synchroniser; idle-high so reset does not look like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM state, bit timer, bit index and assembled byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: mid-bit sampling after a half-bit start qualification.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          // A line that is high again at mid-start was a glitch.
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_en  = 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            stop_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Hold off until the line returns high so a break is one error.
            stop_bad = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-bit load of the sampled data bit, LSB first.
  for (genvar gi = 0; gi < 8; gi++) begin : g_shift
    assign shift_d[gi] = (shift_en && (bit_idx_q == 3'(gi))) ? rx_s_q : shift_q[gi];
  end

  assign full     = (count_q == CNT_FW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign data_sel = (i_address == DATA_ADDR);
  assign stat_sel = (i_address == STAT_ADDR);
  assign pop      = i_ren && data_sel && !empty;
  assign stat_rd  = i_ren && stat_sel;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = stop_ok && (!full || pop);
  assign ovr_set  = stop_ok && full && !pop;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // Occupancy next value from the push/pop pair.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky flags: a set in the same cycle as a status read wins.
  always_comb begin
    overrun_d   = ovr_set  | (overrun_q   & ~stat_rd);
    frame_err_d = stop_bad | (frame_err_q & ~stat_rd);
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign count3 = 3'(count_q);
  assign status = {25'b0, count3, frame_err_q, overrun_q, full, !empty};

  // Combinational register read mux; the LSU ORs this in when o_hit is high.
  always_comb begin
    o_rdata = '0;
    if (data_sel) begin
      if (!empty) o_rdata = {24'b0, mem_q[rd_ptr_q]};
    end else if (stat_sel) begin
      o_rdata = status;
    end
  end

  assign o_hit      = data_sel || stat_sel;
  assign o_rx_avail = !empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio at 16 clocks per bit: frames are bit-banged on the
// falling clock edge, received bytes are tracked in a scoreboard queue and
// compared when popped through the data register.
module tb_uart_rx_mmio;

  localparam logic [31:0] DATA_A  = 32'h10000004;
  localparam logic [31:0] STAT_A  = 32'h10000008;
  localparam logic [31:0] OTHER_A = 32'h10000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        hit;
  logic        avail;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q [$];

  typedef struct {
    logic [7:0]  data;
    bit          accept;
    bit          pop_at_stop;
    logic [31:0] exp_stat;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  uart_rx_mmio #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .FIFO_DEPTH(4),
    .DATA_ADDR (DATA_A),
    .STAT_ADDR (STAT_A)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rx      (rx),
    .i_ren     (ren),
    .i_address (addr),
    .o_rdata   (rdata),
    .o_hit     (hit),
    .o_rx_avail(avail)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Non-destructive status look (no load enable) plus the avail pin.
  task automatic peek_stat(input string name, input logic [31:0] exp);
    ren  = 1'b0;
    addr = STAT_A;
    #1;
    check(name, rdata, exp);
    check({name, "_avail"}, 32'(avail), 32'(exp[0]));
    addr = '0;
  endtask

  task automatic read_stat(input string name, input logic [31:0] exp);
    ren  = 1'b1;
    addr = STAT_A;
    #1;
    check(name, rdata, exp);
    @(negedge clk);
    ren  = 1'b0;
    addr = '0;
  endtask

  task automatic read_data(input string name);
    logic [31:0] exp;
    exp = '0;
    if (sb_q.size() > 0) exp = {24'b0, sb_q.pop_front()};
    ren  = 1'b1;
    addr = DATA_A;
    #1;
    check(name, rdata, exp);
    @(negedge clk);
    ren  = 1'b0;
    addr = '0;
  endtask

  // mode 0: plain frame; 1: data read during the stop-sample cycle;
  // 2: check avail just before/after the push edge; 3: abort inside data bit 3.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int mode);
    logic [31:0] exp;
    for (int c = 0; c < 160; c++) begin
      int b;
      b = c / 16;
      if (b == 0)      rx = 1'b0;
      else if (b <= 8) rx = d[b-1];
      else             rx = stop;
      if (mode == 3 && c == 72) return;
      if (mode == 1 && c == 154) begin
        exp = '0;
        if (sb_q.size() > 0) exp = {24'b0, sb_q.pop_front()};
        ren  = 1'b1;
        addr = DATA_A;
        #1;
        check("stop_cycle_pop", rdata, exp);
      end
      if (mode == 1 && c == 155) begin
        ren  = 1'b0;
        addr = '0;
      end
      if (mode == 2 && c == 154) begin
        #1;
        check("avail_before_push", 32'(avail), 32'h0);
      end
      if (mode == 2 && c == 155) begin
        #1;
        check("avail_after_push", 32'(avail), 32'h1);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_row(input vec_t v, input int idx);
    if (v.accept) sb_q.push_back(v.data);
    send_frame(v.data, 1'b1, v.pop_at_stop ? 1 : 0);
    peek_stat($sformatf("row%0d_stat", idx), v.exp_stat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ren   = 1'b0;
    addr  = '0;

    //          data   acc   pop   status
    tbl[0] = '{8'h01, 1'b1, 1'b0, 32'h11};
    tbl[1] = '{8'h02, 1'b1, 1'b0, 32'h21};
    tbl[2] = '{8'h03, 1'b1, 1'b0, 32'h31};
    tbl[3] = '{8'h04, 1'b1, 1'b0, 32'h43};
    tbl[4] = '{8'h05, 1'b0, 1'b0, 32'h47};
    tbl[5] = '{8'h61, 1'b1, 1'b0, 32'h11};
    tbl[6] = '{8'h62, 1'b1, 1'b0, 32'h21};
    tbl[7] = '{8'h63, 1'b1, 1'b0, 32'h31};
    tbl[8] = '{8'h64, 1'b1, 1'b0, 32'h43};
    tbl[9] = '{8'h55, 1'b1, 1'b1, 32'h43};

    // Reset state and address decode.
    repeat (3) @(negedge clk);
    peek_stat("reset_stat", 32'h0);
    addr = DATA_A;  #1; check("hit_data", 32'(hit), 32'h1); check("rdata_empty", rdata, 32'h0);
    addr = STAT_A;  #1; check("hit_stat", 32'(hit), 32'h1);
    addr = OTHER_A; #1; check("hit_other", 32'(hit), 32'h0); check("rdata_other", rdata, 32'h0);
    addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame, push latency, pop.
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 2);
    peek_stat("t1_stat", 32'h11);
    read_data("t1_data");
    peek_stat("t1_stat_after", 32'h00);

    // Start-bit glitch.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    peek_stat("t2_glitch", 32'h00);

    // Framing error followed by a held break, then a good frame.
    send_frame(8'h3C, 1'b0, 0);
    repeat (48) @(negedge clk);
    peek_stat("t3_break", 32'h08);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0);
    read_stat("t3_stat1", 32'h19);
    read_stat("t3_stat2", 32'h11);
    read_data("t3_data");

    // Overrun: five frames into a four-entry FIFO.
    for (int i = 0; i < 5; i++) run_row(tbl[i], i);
    read_stat("t4_stat_clr", 32'h47);
    peek_stat("t4_stat_after", 32'h43);
    for (int i = 0; i < 5; i++) read_data($sformatf("t4_data%0d", i));
    peek_stat("t4_drained", 32'h00);

    // Full FIFO with a pop on the exact stop-sample cycle.
    for (int i = 5; i < 10; i++) run_row(tbl[i], i);
    for (int i = 0; i < 4; i++) read_data($sformatf("t5_data%0d", i));
    peek_stat("t5_drained", 32'h00);

    // Reset in the middle of a frame.
    sb_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 0);
    peek_stat("t6_pre", 32'h11);
    send_frame(8'h7E, 1'b1, 3);
    rx    = 1'b1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("t6_avail_in_reset", 32'(avail), 32'h0);
    peek_stat("t6_stat_in_reset", 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    peek_stat("t6_after_release", 32'h00);
    sb_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 0);
    peek_stat("t6_stat", 32'h11);
    read_data("t6_data");
    peek_stat("t6_final", 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
